// File: rtl/cmd_icd_pkg.sv
// Shared command-interface definitions for the outbound command stream arbiter
// and the task handlers that feed it.
package cmd_icd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Default stall budget for a granted requester. Task handlers size their own
  // timeouts above this so the arbiter watchdog always fires first.
  localparam int unsigned CMD_ARB_MAX_IDLE = 32'd100000;

  // Next index after idx, wrapping explicitly so non-power-of-two counts work.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cmd_stream_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request found when
// searching ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  int            pos;
  logic [IW-1:0] pos_idx;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IW'(pos);
      if (req_i[pos_idx]) begin
        any_o = 1'b1;
        idx_o = pos_idx;
      end
    end
  end

endmodule

// File: rtl/cmd_stream_arb.sv
// Packet-granular round-robin arbiter sharing one outbound command stream among
// N_REQ requesters, with a mid-packet stall watchdog and a registered output
// slice that isolates downstream timing from requester logic.
//
//   state | meaning
//   IDLE  | no owner; pick the next requester starting at rr_ptr
//   GRANT | grant_id owns the stream until its last word or watchdog expiry
module cmd_stream_arb
  import cmd_icd_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int          DATA_W   = 32,
  parameter int unsigned MAX_IDLE = CMD_ARB_MAX_IDLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       aso_cmd_ready,
  output logic                       aso_cmd_valid,
  output logic [DATA_W-1:0]          aso_cmd_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       abort_pulse,
  output logic [$clog2(N_REQ)-1:0]   abort_id
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t        state_q;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [31:0]       idle_cnt_q;
  logic              abort_q;
  logic [IW-1:0]     abort_id_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              slice_open;
  logic              xfer;
  logic [IW-1:0]     next_ptr;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Route the current owner's lane onto the shared select signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The slice can take a word when empty or when its word drains this cycle.
  assign slice_open = !out_valid_q || aso_cmd_ready;
  assign xfer       = (state_q == GRANT) && sel_valid && slice_open;
  assign next_ptr   = IW'(rr_next(int'(grant_q), N_REQ));

  // Only the owner sees ready, and only while the slice can accept.
  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && slice_open) req_ready[grant_q] = 1'b1;
  end

  // Arbitration FSM with watchdog; a last-word transfer beats watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            idle_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            idle_cnt_q <= '0;
            if (sel_last) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_ptr;
            end
          end else if (idle_cnt_q == MAX_IDLE) begin
            state_q    <= IDLE;
            abort_q    <= 1'b1;
            abort_id_q <= grant_q;
            rr_ptr_q   <= next_ptr;
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single-entry output slice; a held word keeps draining after the grant ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
    end else if (aso_cmd_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign aso_cmd_valid = out_valid_q;
  assign aso_cmd_data  = out_data_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == GRANT);
  assign abort_pulse   = abort_q;
  assign abort_id      = abort_id_q;

endmodule

// File: tb/tb_cmd_stream_arb.sv
// Self-checking bench for cmd_stream_arb: directed scenarios plus a randomized
// phase, all compared against a behavioural model built from requester word
// queues and an expected-output queue.
module tb_cmd_stream_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MI = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            aso_cmd_ready;
  logic            aso_cmd_valid;
  logic [DW-1:0]   aso_cmd_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            abort_pulse;
  logic [1:0]      abort_id;

  cmd_stream_arb #(.N_REQ(N), .DATA_W(DW), .MAX_IDLE(MI)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .aso_cmd_ready (aso_cmd_ready),
    .aso_cmd_valid (aso_cmd_valid),
    .aso_cmd_data  (aso_cmd_data),
    .grant_id      (grant_id),
    .busy          (busy),
    .abort_pulse   (abort_pulse),
    .abort_id      (abort_id)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // requester-side word queues and controls
  logic [31:0] w_q [N][$];
  bit          l_q [N][$];
  bit          hold [N];
  bit          acc  [N];
  bit          rgate;
  int          rseq [N];

  // behavioural model: who owns the stream, where the search starts, how long
  // the owner has stalled, and what the output slice should hold
  bit          m_busy;
  int          m_g;
  int          m_ptr;
  int          m_cnt;
  bit          m_abort;
  int          m_aid;
  logic [31:0] exp_q[$];

  logic [31:0] obs_q[$];
  int          edges;
  int          n_abort;
  int          last_abort_edge;

  task automatic push_word(input int r, input logic [31:0] w, input bit last);
    w_q[r].push_back(w);
    l_q[r].push_back(last);
  endtask

  task automatic push_pkt(input int r, input int len, input logic [31:0] base);
    for (int k = 0; k < len; k++) push_word(r, base + 32'(k), k == len - 1);
  endtask

  task automatic drive();
    bit v;
    for (int i = 0; i < N; i++) begin
      v = (w_q[i].size() > 0) && !hold[i] && (!rgate || $urandom_range(4) != 0);
      req_valid[i] = v;
      req_data[i*DW +: DW] = v ? w_q[i][0] : $urandom;
      req_last[i] = v ? l_q[i][0] : 1'b0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    int j;
    drive();
    #1;
    er = '0;
    if (m_busy && (exp_q.size() == 0 || aso_cmd_ready)) er[m_g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (!rst && aso_cmd_valid && aso_cmd_ready) obs_q.push_back(aso_cmd_data);
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_g = 0; m_ptr = 0; m_cnt = 0; m_abort = 1'b0; m_aid = 0;
      exp_q.delete();
    end else begin
      m_abort = 1'b0;
      if (exp_q.size() != 0 && aso_cmd_ready) void'(exp_q.pop_front());
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (req_valid[j]) begin
            m_g = j; m_busy = 1'b1; m_cnt = 0;
            break;
          end
        end
      end else if (req_valid[m_g] && er[m_g]) begin
        exp_q.push_back(w_q[m_g][0]);
        acc[m_g] = 1'b1;
        m_cnt = 0;
        if (l_q[m_g][0]) begin
          m_busy = 1'b0;
          m_ptr  = (m_g + 1) % N;
        end
      end else if (m_cnt == MI) begin
        m_busy = 1'b0; m_abort = 1'b1; m_aid = m_g; m_ptr = (m_g + 1) % N;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    edges++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(w_q[i].pop_front());
        void'(l_q[i].pop_front());
      end
    end
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("grant_id", 64'(grant_id), 64'(m_g));
    chk("out_valid", 64'(aso_cmd_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_data", 64'(aso_cmd_data), 64'(exp_q[0]));
    chk("abort_pulse", 64'(abort_pulse), 64'(m_abort));
    if (m_abort) begin
      chk("abort_id", 64'(abort_id), 64'(m_aid));
      n_abort++;
      last_abort_edge = edges;
    end
  endtask

  function automatic bit quiet();
    bit q = !m_busy && (exp_q.size() == 0);
    for (int i = 0; i < N; i++) if (w_q[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (n < budget && !quiet()) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, 64'(quiet()), 64'd1);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      w_q[i].delete();
      l_q[i].delete();
      hold[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e_x;
    rgate = 1'b0;
    edges = 0; n_abort = 0; last_abort_edge = 0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 1'b0; acc[i] = 1'b0; rseq[i] = 0;
    end
    rst = 1'b1;
    aso_cmd_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    cycle();
    rst = 1'b0;
    chk("rst_valid", 64'(aso_cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_abort", 64'(abort_pulse), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // single requester, 3-word packet, ready held high
    obs_q.delete();
    push_pkt(0, 3, 32'hA0);
    cycle();
    chk("t1_grant_lat", 64'(busy), 64'd1);
    repeat (4) cycle();
    chk("t1_count", 64'(obs_q.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < obs_q.size()) chk("t1_word", 64'(obs_q[k]), 64'(32'hA0 + 32'(k)));
    chk("t1_busy_end", 64'(busy), 64'd0);
    run_idle("t1", 20);

    // backpressure mid-packet
    obs_q.delete();
    push_pkt(0, 6, 32'hB0);
    repeat (4) cycle();
    aso_cmd_ready = 1'b0;
    repeat (5) cycle();
    aso_cmd_ready = 1'b1;
    run_idle("t2", 40);
    cycle();
    chk("t2_count", 64'(obs_q.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      if (k < obs_q.size()) chk("t2_word", 64'(obs_q[k]), 64'(32'hB0 + 32'(k)));

    // watchdog: requester 1 stalls mid-packet, requester 3 waiting
    obs_q.delete();
    n_abort = 0;
    push_word(1, 32'hC0, 1'b0);
    push_pkt(3, 1, 32'hD0);
    e_x = -1;
    for (int n = 0; n < 10 && e_x < 0; n++) begin
      cycle();
      if (acc[1]) e_x = edges;
    end
    chk("t3_xfer", 64'(e_x >= 0), 64'd1);
    run_idle("t3", 60);
    repeat (3) cycle();
    chk("t3_aborts", 64'(n_abort), 64'd1);
    chk("t3_abort_lat", 64'(last_abort_edge - e_x), 64'd17);
    chk("t3_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) chk("t3_after", 64'(obs_q[1]), 64'(32'hD0));

    // last word lands exactly when the stall counter reaches its limit
    n_abort = 0;
    push_word(2, 32'hE0, 1'b0);
    push_word(2, 32'hE1, 1'b1);
    for (int n = 0; n < 10 && !acc[2]; n++) cycle();
    chk("t4_first", 64'(acc[2]), 64'd1);
    hold[2] = 1'b1;
    repeat (16) cycle();
    hold[2] = 1'b0;
    cycle();
    chk("t4_last_xfer", 64'(acc[2]), 64'd1);
    chk("t4_no_abort", 64'(n_abort), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);
    run_idle("t4", 20);

    // two requesters, two rounds, from a fresh reset
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      obs_q.delete();
      push_pkt(0, 2, 32'h10);
      push_pkt(2, 2, 32'h20);
      run_idle("t5", 40);
      cycle();
      chk("t5_count", 64'(obs_q.size()), 64'd4);
      if (obs_q.size() == 4) begin
        chk("t5_w0", 64'(obs_q[0]), 64'h10);
        chk("t5_w1", 64'(obs_q[1]), 64'h11);
        chk("t5_w2", 64'(obs_q[2]), 64'h20);
        chk("t5_w3", 64'(obs_q[3]), 64'h21);
      end
    end

    // reset mid-packet with the slice full
    push_pkt(0, 5, 32'h50);
    aso_cmd_ready = 1'b0;
    for (int n = 0; n < 10 && exp_q.size() == 0; n++) cycle();
    cycle();
    chk("t6_full", 64'(aso_cmd_valid), 64'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("t6_valid", 64'(aso_cmd_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd0);
    clear_queues();
    aso_cmd_ready = 1'b1;
    obs_q.delete();
    push_pkt(2, 1, 32'h70);
    push_pkt(1, 1, 32'h60);
    run_idle("t6", 30);
    cycle();
    chk("t6_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      chk("t6_first", 64'(obs_q[0]), 64'h60);
      chk("t6_second", 64'(obs_q[1]), 64'h70);
    end

    // randomized traffic with stalls and occasional watchdog expiries
    rgate = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      aso_cmd_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (w_q[i].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          len = int'($urandom_range(4, 1));
          push_pkt(i, len, {4'(i), 28'(rseq[i])});
          rseq[i] += len;
        end
        if (hold[i]) begin
          if ($urandom_range(19) == 0) hold[i] = 1'b0;
        end else if ($urandom_range(99) == 0) begin
          hold[i] = 1'b1;
        end
      end
      obs_q.delete();
      cycle();
    end
    rgate = 1'b0;
    aso_cmd_ready = 1'b1;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    run_idle("rand", 500);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
